byte_pair_packer: RTL and testbench
===================================

// Module: byte_pair_packer
// PURPOSE
//  Upstream feeder for the 16-bit word register/byte-swap stage: packs a valid/ready byte stream into 16-bit words.
//  Holds the first byte of a pair, joins it with the second, and presents the word in a registered output slot.
//  Sustains 1 byte/cycle in and 1 word per 2 cycles out; counts emitted words for debug.
// PARAMETERS
//  FIRST_HIGH  1   1: first byte of pair -> dataout[15:8]; 0: first byte -> dataout[7:0]
//  COUNT_W     16  width of word_count; counter wraps modulo 2**COUNT_W
// PORTS
//  clock          in   1        single clock; all state updates on posedge
//  reset          in   1        synchronous, active-high
//  bytein         in   8        input byte
//  bytein_valid   in   1        bytein is valid this cycle
//  bytein_ready   out  1        packer accepts bytein this cycle (transfer = valid & ready)
//  dataout        out  16       packed word, registered
//  dataout_valid  out  1        dataout holds a word
//  dataout_ready  in   1        downstream takes dataout this cycle
//  word_count     out  COUNT_W  number of words emitted (transfers on the output)
//  flush          in   1        [BYTE_PACKER_FLUSH_EN only] level request to emit a pending odd byte
//  dataout_pad    out  1        [BYTE_PACKER_FLUSH_EN only] dataout second byte is PAD_BYTE
// BEHAVIOUR
//  - Reset (sync, active-high): half_valid=0, dataout_valid=0, dataout=16'h0000, word_count=0, dataout_pad=0.
//    Reset mid-pair discards the held byte; reset while dataout_valid=1 drops the word (no output transfer).
//  - State: EMPTY (half_valid=0) and HALF (half_valid=1, first byte held); the output slot is independent (dataout_valid).
//  - EMPTY: bytein_ready=1; an accepted byte is stored -> HALF.
//  - HALF: bytein_ready = !dataout_valid | dataout_ready. An accepted byte forms the word in the same cycle.
//    The word is loaded into dataout and dataout_valid=1 on the next edge -> EMPTY. Latency: second byte in -> word out = 1 cycle.
//  - Output slot: a transfer occurs when dataout_valid & dataout_ready. The slot clears unless reloaded in the same cycle.
//    A simultaneous drain and load keeps dataout_valid=1 with the new word, giving back-to-back words.
//  - dataout and dataout_pad are stable while dataout_valid=1 and dataout_ready=0.
//  - Byte placement: FIRST_HIGH=1 -> {first,second}; FIRST_HIGH=0 -> {second,first}.
//  - word_count increments by 1 on each output transfer; 2**COUNT_W-1 -> 0 wrap.
//  - bytein_valid=0: no state change on the input side. bytein is ignored when no transfer occurs.
// CONFIGURATION
//  Macro BYTE_PACKER_FLUSH_EN.
//  - Defined: the flush and dataout_pad ports exist.
//    A padded word {held,PAD_BYTE} (or {PAD_BYTE,held} when FIRST_HIGH=0) is loaded, with dataout_pad=1, on the first cycle that meets all of:
//    flush=1, HALF, no byte accepted, slot free or draining. State then goes to EMPTY.
//  - A byte accepted in the same cycle as flush completes the word normally (dataout_pad=0).
//  - flush in EMPTY has no effect. flush stays high until the caller sees the padded word.
//  - Not defined: no flush/dataout_pad ports; an odd trailing byte waits in HALF indefinitely.
// STRUCTURE
//  - Package hw13_pkg: BYTE_W=8, WORD_W=16, PAD_BYTE=8'h00, typedef enum logic {EMPTY,HALF} pack_state_t.
//  - Sub-module hw13_out_slice: a WORD_W(+pad bit) valid/ready output register with load/drain.
//    Used here; reusable downstream.
//  - The top holds the state FSM, the held-byte register, word assembly and word_count.
// TESTING
//  - Reset: drive reset=1 for 2 cycles with bytein_valid=1.
//    -> bytein_ready=1, dataout_valid=0, dataout=0, word_count=0; no words after release.
//  - Streaming: bytes 8'hA1,8'hB2,8'hC3,8'hD4 on consecutive cycles, dataout_ready=1, FIRST_HIGH=1.
//    -> 16'hA1B2 then 16'hC3D4, each 1 cycle after its second byte; bytein_ready never drops; word_count=2.
//  - Backpressure: dataout_ready=0 with 16'hA1B2 pending, next byte 8'hC3 accepted, then 8'hD4 offered.
//    -> bytein_ready=0 while HALF and slot full; dataout holds A1B2. Raise ready -> A1B2, then C3D4 the next cycle.
//  - Order/wrap: FIRST_HIGH=0, COUNT_W=2, send 10 bytes 8'h01..8'h0A.
//    -> words 16'h0201,16'h0403,...,16'h0A09; word_count sequence 1,2,3,0,1.
//  - Flush (BYTE_PACKER_FLUSH_EN): send 8'h5A then flush=1.
//    -> 16'h5A00 with dataout_pad=1. Flush in the same cycle as byte 8'h3C after 8'h5A -> 16'h5A3C with pad=0.
//  - Mid-pair reset: send 8'h77, pulse reset, then send 8'h11,8'h22.
//    -> only word 16'h1122 appears; 8'h77 never emitted.

Source files
------------

// File: rtl/hw13_pkg.sv
// Shared types and constants for the byte-pair packer and its output register.
// The flush feature is controlled by BYTE_PACKER_FLUSH_EN.
package hw13_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    // Places the first byte of a pair in the high or low half of the word.
    function automatic logic [WORD_W-1:0] join_bytes(
        input logic [BYTE_W-1:0] first_b,
        input logic [BYTE_W-1:0] second_b,
        input logic              first_high
    );
        return first_high ? {first_b, second_b} : {second_b, first_b};
    endfunction

endpackage

// File: rtl/hw13_out_slice.sv
// Single-entry valid/ready output register with load and drain.
// A load in the same cycle as a drain keeps the slot full with the new data.
module hw13_out_slice #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_drain_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_can_load
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_can_load = !r_valid || i_drain_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    // Data only changes on a load, so it is stable while the slot is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (r_valid && i_drain_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_pair_packer.sv
// Packs a valid/ready byte stream into 16-bit words held in a registered output slot.
// Define BYTE_PACKER_FLUSH_EN to add the flush/dataout_pad ports for emitting an odd trailing byte.
module byte_pair_packer
    import hw13_pkg::*;
#(
    parameter int FIRST_HIGH = 1,
    parameter int COUNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         bytein,
    input  logic               bytein_valid,
    output logic               bytein_ready,
    output logic [15:0]        dataout,
    output logic               dataout_valid,
    input  logic               dataout_ready,
    output logic [COUNT_W-1:0] word_count
`ifdef BYTE_PACKER_FLUSH_EN
    ,
    input  logic               flush,
    output logic               dataout_pad
`endif
);

    localparam logic FIRST_IS_HIGH = (FIRST_HIGH != 0);
`ifdef BYTE_PACKER_FLUSH_EN
    localparam int SLICE_W = WORD_W + 1;
`else
    localparam int SLICE_W = WORD_W;
`endif

    pack_state_t          r_state;
    pack_state_t          r_state_next;
    logic [BYTE_W-1:0]    r_held;
    logic [COUNT_W-1:0]   r_word_count;

    logic                 w_accept;
    logic                 w_held_en;
    logic                 w_load;
    logic [WORD_W-1:0]    w_load_word;
    logic                 w_load_pad;
    logic                 w_slot_free;
    logic                 w_slot_valid;
    logic [SLICE_W-1:0]   w_slice_in;
    logic [SLICE_W-1:0]   w_slice_out;

    assign bytein_ready = (r_state == EMPTY) || w_slot_free;
    assign w_accept     = bytein_valid && bytein_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        w_held_en    = 1'b0;
        w_load       = 1'b0;
        w_load_word  = '0;
        w_load_pad   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_held_en    = 1'b1;
                    r_state_next = HALF;
                end
            end
            HALF: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_load_word  = join_bytes(r_held, bytein, FIRST_IS_HIGH);
                    r_state_next = EMPTY;
                end
`ifdef BYTE_PACKER_FLUSH_EN
                // A real second byte always wins over the pad byte.
                else if (flush && w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_word  = join_bytes(r_held, PAD_BYTE, FIRST_IS_HIGH);
                    w_load_pad   = 1'b1;
                    r_state_next = EMPTY;
                end
`endif
            end
            default: r_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_held <= '0;
        end else if (w_held_en) begin
            r_held <= bytein;
        end
    end

`ifdef BYTE_PACKER_FLUSH_EN
    assign w_slice_in  = {w_load_pad, w_load_word};
    assign dataout_pad = w_slice_out[WORD_W];
`else
    assign w_slice_in  = w_load_word;
`endif
    assign dataout       = w_slice_out[WORD_W-1:0];
    assign dataout_valid = w_slot_valid;

    hw13_out_slice #(
        .W (SLICE_W)
    ) u_out_slice (
        .clock         (clock),
        .reset         (reset),
        .i_load        (w_load),
        .i_load_data   (w_slice_in),
        .i_drain_ready (dataout_ready),
        .o_valid       (w_slot_valid),
        .o_data        (w_slice_out),
        .o_can_load    (w_slot_free)
    );

    // Counts output transfers; wraps naturally at 2**COUNT_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word_count <= '0;
        end else if (w_slot_valid && dataout_ready) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    assign word_count = r_word_count;

`ifndef BYTE_PACKER_FLUSH_EN
    logic w_unused_pad;
    assign w_unused_pad = w_load_pad;
`endif

endmodule

// File: tb/tb_byte_pair_packer.sv
// Scoreboard bench for byte_pair_packer: two instances (FIRST_HIGH=1/COUNT_W=16 and FIRST_HIGH=0/COUNT_W=2).
// Flush vectors run only when BYTE_PACKER_FLUSH_EN is defined.
module tb_byte_pair_packer;

    typedef struct packed {
        logic [15:0] word;
        logic        pad;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [7:0]  bin_a = 8'h00;
    logic        bv_a = 1'b0;
    logic        rdy_a;
    logic [15:0] dout_a;
    logic        dv_a;
    logic        dr_a = 1'b1;
    logic [15:0] wc_a;

    logic [7:0]  bin_b = 8'h00;
    logic        bv_b = 1'b0;
    logic        rdy_b;
    logic [15:0] dout_b;
    logic        dv_b;
    logic        dr_b = 1'b1;
    logic [1:0]  wc_b;

`ifdef BYTE_PACKER_FLUSH_EN
    logic        fl_a = 1'b0;
    logic        pad_a;
    logic        fl_b = 1'b0;
    logic        pad_b;
`endif

    int n_vec = 0;
    int n_err = 0;
    int stall_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clock = ~clock;

    byte_pair_packer #(.FIRST_HIGH(1), .COUNT_W(16)) u_dut_a (
        .clock(clock), .reset(reset), .bytein(bin_a), .bytein_valid(bv_a), .bytein_ready(rdy_a),
        .dataout(dout_a), .dataout_valid(dv_a), .dataout_ready(dr_a), .word_count(wc_a)
`ifdef BYTE_PACKER_FLUSH_EN
        , .flush(fl_a), .dataout_pad(pad_a)
`endif
    );

    byte_pair_packer #(.FIRST_HIGH(0), .COUNT_W(2)) u_dut_b (
        .clock(clock), .reset(reset), .bytein(bin_b), .bytein_valid(bv_b), .bytein_ready(rdy_b),
        .dataout(dout_b), .dataout_valid(dv_b), .dataout_ready(dr_b), .word_count(wc_b)
`ifdef BYTE_PACKER_FLUSH_EN
        , .flush(fl_b), .dataout_pad(pad_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, req, $time);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Monitors: pop and compare on every output transfer.
    always @(negedge clock) begin
        if (!reset && dv_a && dr_a) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL word_a: got unexpected %h, required no word (t=%0t)", dout_a, $time);
            end else begin
                exp_t e;
                e = q_a.pop_front();
`ifdef BYTE_PACKER_FLUSH_EN
                check("word_a", {15'b0, pad_a, dout_a}, {15'b0, e.pad, e.word});
`else
                check("word_a", {16'b0, dout_a}, {16'b0, e.word});
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && dv_b && dr_b) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL word_b: got unexpected %h, required no word (t=%0t)", dout_b, $time);
            end else begin
                exp_t e;
                e = q_b.pop_front();
`ifdef BYTE_PACKER_FLUSH_EN
                check("word_b", {15'b0, pad_b, dout_b}, {15'b0, e.pad, e.word});
`else
                check("word_b", {16'b0, dout_b}, {16'b0, e.word});
`endif
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Offers one byte and returns 1ns after the edge on which it was accepted.
    task automatic push_a(input logic [7:0] b);
        int k;
        bin_a = b;
        bv_a  = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rdy_a) break;
            stall_a++;
        end
        if (k == 20) begin
            n_vec++;
            n_err++;
            $display("FAIL push_a timeout: got ready=0 for 20 cycles, required ready=1");
        end
        @(posedge clock);
        #1;
        bv_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] b);
        int k;
        bin_b = b;
        bv_b  = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rdy_b) break;
        end
        if (k == 20) begin
            n_vec++;
            n_err++;
            $display("FAIL push_b timeout: got ready=0 for 20 cycles, required ready=1");
        end
        @(posedge clock);
        #1;
        bv_b = 1'b0;
    endtask

    logic [7:0]  wrap_bytes [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    logic [15:0] wrap_words [5]  = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09};
    logic [1:0]  wrap_count [5]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        // Reset held for two cycles with a valid byte offered.
        bin_a = 8'hEE; bv_a = 1'b1;
        bin_b = 8'hEE; bv_b = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_ready", {31'b0, rdy_a}, 32'd1);
        check("reset_valid", {31'b0, dv_a}, 32'd0);
        check("reset_dout", {16'b0, dout_a}, 32'h0);
        check("reset_count", {16'b0, wc_a}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bv_a = 1'b0;
        bv_b = 1'b0;
        idle(4);

        // Streaming at full rate.
        stall_a = 0;
        push_a(8'hA1);
        q_a.push_back('{word: 16'hA1B2, pad: 1'b0});
        push_a(8'hB2);
        push_a(8'hC3);
        q_a.push_back('{word: 16'hC3D4, pad: 1'b0});
        push_a(8'hD4);
        check("stream_latency_valid", {31'b0, dv_a}, 32'd1);
        check("stream_latency_word", {16'b0, dout_a}, 32'h0000C3D4);
        check("stream_stalls", stall_a, 32'd0);
        idle(3);
        check("stream_count", {16'b0, wc_a}, 32'd2);

        // Backpressure with a full slot and a held byte.
        dr_a = 1'b0;
        q_a.push_back('{word: 16'hA1B2, pad: 1'b0});
        q_a.push_back('{word: 16'hC3D4, pad: 1'b0});
        push_a(8'hA1);
        push_a(8'hB2);
        push_a(8'hC3);
        bin_a = 8'hD4;
        bv_a  = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("bp_ready_low", {31'b0, rdy_a}, 32'd0);
            check("bp_hold_word", {15'b0, dv_a, dout_a}, {15'b0, 1'b1, 16'hA1B2});
        end
        @(posedge clock);
        #1;
        dr_a = 1'b1;
        @(negedge clock);
        check("bp_ready_high", {31'b0, rdy_a}, 32'd1);
        @(posedge clock);
        #1;
        bv_a = 1'b0;
        check("bp_backtoback", {15'b0, dv_a, dout_a}, {15'b0, 1'b1, 16'hC3D4});
        idle(2);
        check("bp_count", {16'b0, wc_a}, 32'd4);

        // Mid-pair reset discards the held byte.
        push_a(8'h77);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        q_a.push_back('{word: 16'h1122, pad: 1'b0});
        push_a(8'h11);
        push_a(8'h22);
        idle(3);
        check("midreset_count", {16'b0, wc_a}, 32'd1);

        // Low-first order and 2-bit counter wrap.
        for (int i = 0; i < 5; i++) begin
            q_b.push_back('{word: wrap_words[i], pad: 1'b0});
            push_b(wrap_bytes[2*i]);
            push_b(wrap_bytes[2*i+1]);
            idle(1);
            check("wrap_count", {30'b0, wc_b}, {30'b0, wrap_count[i]});
        end

`ifdef BYTE_PACKER_FLUSH_EN
        // Flush of a lone byte, then flush coinciding with a real second byte.
        q_a.push_back('{word: 16'h5A00, pad: 1'b1});
        push_a(8'h5A);
        fl_a = 1'b1;
        idle(3);
        fl_a = 1'b0;
        q_a.push_back('{word: 16'h5A3C, pad: 1'b0});
        push_a(8'h5A);
        fl_a = 1'b1;
        push_a(8'h3C);
        fl_a = 1'b0;
        idle(3);
        fl_a = 1'b1;
        idle(3);
        fl_a = 1'b0;
        check("flush_count", {16'b0, wc_a}, 32'd3);
`endif

        idle(4);
        check("queue_a_empty", q_a.size(), 32'd0);
        check("queue_b_empty", q_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, required finish");
        $fatal(1, "watchdog");
    end

endmodule
